sequencer_adc_sample_avg: RTL and testbench

- Upstream stage of the voltage-monitor decoder.
- Accepts raw Avalon-ST samples from the Modular ADC sequencer and maps each physical ADC channel to a logical rail (0=VIN, 1..VRAILS=VOUTs).
- Boxcar-averages 2^AVG_LOG2 samples per rail and presents one averaged level per rail to the decoder.
- Flags rails whose ADC data has gone stale.

---
 rtl/sequencer_adc_sample_avg_if.sv | 30 +++
 rtl/sequencer_adc_sample_avg.sv | 135 +++++++++++++
 tb/tb_sequencer_adc_sample_avg.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequencer_adc_sample_avg_if.sv
// Sample stream from the Modular ADC sequencer plus the averaged per-rail view
// that is handed to the voltage-monitor decoder.
interface sequencer_adc_sample_avg_if #(
    parameter int DATA_WIDTH = 12,
    parameter int VRAILS     = 6
);
    localparam int RAIL_W = (VRAILS > 0) ? $clog2(VRAILS + 1) : 1;

    logic                             adc_valid;
    logic [4:0]                       adc_channel;
    logic [DATA_WIDTH-1:0]            adc_data;
    logic                             flush;
    logic                             avg_valid;
    logic [RAIL_W-1:0]                avg_rail;
    logic [DATA_WIDTH-1:0]            avg_data;
    logic [(VRAILS+1)*DATA_WIDTH-1:0] vrail_level;
    logic [VRAILS:0]                  vrail_fresh;
    logic [VRAILS:0]                  vrail_stale;
    logic                             chan_err;

    modport master (
        output adc_valid, adc_channel, adc_data, flush,
        input  avg_valid, avg_rail, avg_data, vrail_level, vrail_fresh, vrail_stale, chan_err
    );

    modport slave (
        input  adc_valid, adc_channel, adc_data, flush,
        output avg_valid, avg_rail, avg_data, vrail_level, vrail_fresh, vrail_stale, chan_err
    );
endinterface

// File: rtl/sequencer_adc_sample_avg.sv
// Maps physical ADC channels onto logical rails, boxcar-averages 2^AVG_LOG2
// samples per rail and tracks per-rail freshness/staleness.
module sequencer_adc_sample_avg #(
    parameter int ADC_CHANNELS = 9,
    parameter int VRAILS       = 6,
    parameter int DATA_WIDTH   = 12,
    parameter int AVG_LOG2     = 2,
    parameter int STALE_CYCLES = 4096,
    parameter int CHAN_MAP [0:ADC_CHANNELS-1] = '{199, 0, 1, 2, 3, 4, 5, 199, 6}
) (
    input  logic                      clock,
    input  logic                      reset,
    sequencer_adc_sample_avg_if.slave bus
);
    localparam int RAIL_W  = (VRAILS > 0) ? $clog2(VRAILS + 1) : 1;
    localparam int ACC_W   = DATA_WIDTH + AVG_LOG2;
    localparam int CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

    logic                             in_range;
    logic                             map_ok;
    logic                             accept;
    logic                             complete;
    logic [RAIL_W-1:0]                map_rail;
    logic [(VRAILS+1)*ACC_W-1:0]      acc_flat;
    logic [VRAILS:0]                  cnt_last;
    logic [ACC_W-1:0]                 acc_sel;
    logic [ACC_W-1:0]                 sum_sel;
    logic [DATA_WIDTH-1:0]            avg_sel;
    logic [(VRAILS+1)*DATA_WIDTH-1:0] level_flat;
    logic [VRAILS:0]                  fresh_vec;
    logic [VRAILS:0]                  stale_vec;

    logic                             avg_valid_reg;
    logic [RAIL_W-1:0]                avg_rail_reg;
    logic [DATA_WIDTH-1:0]            avg_data_reg;
    logic                             chan_err_reg;

    always_comb begin
        map_ok   = 1'b0;
        map_rail = '0;
        for (int c = 0; c < ADC_CHANNELS; c++) begin
            if (int'(bus.adc_channel) == c && CHAN_MAP[c] >= 0 && CHAN_MAP[c] <= VRAILS) begin
                map_ok   = 1'b1;
                map_rail = RAIL_W'(CHAN_MAP[c]);
            end
        end
    end

    // Only one rail can take a sample per cycle, so a single shared adder serves all rails.
    assign in_range = int'(bus.adc_channel) < ADC_CHANNELS;
    assign accept   = bus.adc_valid & ~bus.flush & in_range & map_ok;
    assign acc_sel  = acc_flat[map_rail*ACC_W +: ACC_W];
    assign sum_sel  = acc_sel + ACC_W'(bus.adc_data);
    assign avg_sel  = DATA_WIDTH'(sum_sel >> AVG_LOG2);
    assign complete = accept & cnt_last[map_rail];

    for (genvar gi = 0; gi <= VRAILS; gi++) begin : g_rail
        logic [ACC_W-1:0]      acc_reg;
        logic [CNT_W-1:0]      cnt_reg;
        logic [STALE_W-1:0]    stale_reg;
        logic [DATA_WIDTH-1:0] level_reg;
        logic                  fresh_reg;
        logic                  hit;
        logic                  done;

        assign hit          = accept && (map_rail == RAIL_W'(gi));
        assign done         = hit && cnt_last[gi];
        assign cnt_last[gi] = (cnt_reg == CNT_LAST);
        assign acc_flat[gi*ACC_W +: ACC_W] = acc_reg;

        always_ff @(posedge clock) begin
            if (reset) begin
                acc_reg   <= '0;
                cnt_reg   <= '0;
                stale_reg <= '0;
                level_reg <= '0;
                fresh_reg <= 1'b0;
            end else begin
                if (bus.flush) begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                end else if (hit) begin
                    if (cnt_last[gi]) begin
                        acc_reg <= '0;
                        cnt_reg <= '0;
                    end else begin
                        acc_reg <= sum_sel;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                // Only a completed average proves the rail alive; partial samples do not.
                if (done) begin
                    level_reg <= avg_sel;
                    fresh_reg <= 1'b1;
                    stale_reg <= '0;
                end else if (stale_reg != STALE_MAX) begin
                    stale_reg <= stale_reg + 1'b1;
                end
            end
        end

        assign level_flat[gi*DATA_WIDTH +: DATA_WIDTH] = level_reg;
        assign fresh_vec[gi] = fresh_reg;
        assign stale_vec[gi] = (stale_reg == STALE_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            avg_valid_reg <= 1'b0;
            avg_rail_reg  <= '0;
            avg_data_reg  <= '0;
            chan_err_reg  <= 1'b0;
        end else begin
            avg_valid_reg <= complete;
            if (complete) begin
                avg_rail_reg <= map_rail;
                avg_data_reg <= avg_sel;
            end
            if (bus.adc_valid && !in_range) begin
                chan_err_reg <= 1'b1;
            end
        end
    end

    assign bus.avg_valid   = avg_valid_reg;
    assign bus.avg_rail    = avg_rail_reg;
    assign bus.avg_data    = avg_data_reg;
    assign bus.vrail_level = level_flat;
    assign bus.vrail_fresh = fresh_vec;
    assign bus.vrail_stale = stale_vec;
    assign bus.chan_err    = chan_err_reg;
endmodule

// File: tb/tb_sequencer_adc_sample_avg.sv
// Bench for the rail averager: a 4-sample build with a short stale window and a
// pass-through build, both checked against a queue of expected averages.
module tb_sequencer_adc_sample_avg;
    localparam int DW = 12;
    localparam int VR = 6;

    typedef struct {
        logic [2:0]  rail;
        logic [11:0] data;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q_a[$];
    exp_t q_p[$];
    exp_t ea;
    exp_t ma;
    exp_t mp;

    sequencer_adc_sample_avg_if #(.DATA_WIDTH(DW), .VRAILS(VR)) bus_a ();
    sequencer_adc_sample_avg_if #(.DATA_WIDTH(DW), .VRAILS(VR)) bus_p ();

    sequencer_adc_sample_avg #(.STALE_CYCLES(16)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    sequencer_adc_sample_avg #(.AVG_LOG2(0)) dut_p (
        .clock (clock),
        .reset (reset),
        .bus   (bus_p)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitors: every avg_valid pulse must match the head of its queue, on time.
    always @(negedge clock) begin
        if (bus_a.avg_valid === 1'b1) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL avg_a_unexpected: rail=%0d data=%0d cyc=%0d, required no pulse",
                         bus_a.avg_rail, bus_a.avg_data, cyc);
            end else begin
                ma = q_a.pop_front();
                if (bus_a.avg_rail !== ma.rail || bus_a.avg_data !== ma.data || cyc != ma.due) begin
                    bad++;
                    $display("FAIL avg_a: got rail=%0d data=%0d cyc=%0d, required rail=%0d data=%0d cyc=%0d",
                             bus_a.avg_rail, bus_a.avg_data, cyc, ma.rail, ma.data, ma.due);
                end else begin
                    $display("txn a: rail=%0d data=%0d cyc=%0d ok", bus_a.avg_rail, bus_a.avg_data, cyc);
                end
            end
        end
        if (bus_p.avg_valid === 1'b1) begin
            total++;
            if (q_p.size() == 0) begin
                bad++;
                $display("FAIL avg_p_unexpected: rail=%0d data=%0d cyc=%0d, required no pulse",
                         bus_p.avg_rail, bus_p.avg_data, cyc);
            end else begin
                mp = q_p.pop_front();
                if (bus_p.avg_rail !== mp.rail || bus_p.avg_data !== mp.data || cyc != mp.due) begin
                    bad++;
                    $display("FAIL avg_p: got rail=%0d data=%0d cyc=%0d, required rail=%0d data=%0d cyc=%0d",
                             bus_p.avg_rail, bus_p.avg_data, cyc, mp.rail, mp.data, mp.due);
                end else begin
                    $display("txn p: rail=%0d data=%0d cyc=%0d ok", bus_p.avg_rail, bus_p.avg_data, cyc);
                end
            end
        end
    end

    task automatic drive_a(input logic v, input logic [4:0] ch, input logic [11:0] d, input logic fl);
        @(posedge clock);
        #1;
        bus_a.adc_valid   = v;
        bus_a.adc_channel = ch;
        bus_a.adc_data    = d;
        bus_a.flush       = fl;
    endtask

    task automatic drive_p(input logic v, input logic [4:0] ch, input logic [11:0] d);
        @(posedge clock);
        #1;
        bus_p.adc_valid   = v;
        bus_p.adc_channel = ch;
        bus_p.adc_data    = d;
        bus_p.flush       = 1'b0;
    endtask

    task automatic expect_a(input logic [2:0] rail, input logic [11:0] data);
        ea.rail = rail;
        ea.data = data;
        ea.due  = cyc + 1;
        q_a.push_back(ea);
    endtask

    task automatic do_reset;
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus_a.adc_valid = 1'b0;
        bus_a.flush     = 1'b0;
        bus_p.adc_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        bus_a.adc_valid = 1'b1; bus_a.adc_channel = 5'd1; bus_a.adc_data = 12'd77; bus_a.flush = 1'b0;
        bus_p.adc_valid = 1'b1; bus_p.adc_channel = 5'd3; bus_p.adc_data = 12'd77; bus_p.flush = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (bus_a.avg_valid !== 1'b0) begin bad++; $display("FAIL reset_avg_valid: got %b required 0", bus_a.avg_valid); end
        total++; if (bus_a.avg_rail !== 3'd0) begin bad++; $display("FAIL reset_avg_rail: got %0d required 0", bus_a.avg_rail); end
        total++; if (bus_a.avg_data !== 12'd0) begin bad++; $display("FAIL reset_avg_data: got %0d required 0", bus_a.avg_data); end
        total++; if (bus_a.vrail_level !== '0) begin bad++; $display("FAIL reset_level: got %h required 0", bus_a.vrail_level); end
        total++; if (bus_a.vrail_fresh !== 7'd0) begin bad++; $display("FAIL reset_fresh: got %b required 0", bus_a.vrail_fresh); end
        total++; if (bus_a.vrail_stale !== 7'd0) begin bad++; $display("FAIL reset_stale: got %b required 0", bus_a.vrail_stale); end
        total++; if (bus_a.chan_err !== 1'b0) begin bad++; $display("FAIL reset_chan_err: got %b required 0", bus_a.chan_err); end
        total++;
        if ({bus_p.avg_valid, bus_p.avg_rail, bus_p.avg_data, bus_p.vrail_level,
             bus_p.vrail_fresh, bus_p.vrail_stale, bus_p.chan_err} !== '0) begin
            bad++;
            $display("FAIL reset_p_outputs: got valid=%b data=%0d fresh=%b required all 0",
                     bus_p.avg_valid, bus_p.avg_data, bus_p.vrail_fresh);
        end
        bus_a.adc_valid = 1'b0;
        bus_p.adc_valid = 1'b0;
    endtask

    task automatic test_stale;
        logic [5:0] exp_hi;
        logic       exp_r0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            if (j <= 40) begin
                bus_a.adc_valid   = 1'b1;
                bus_a.adc_channel = 5'd1;
                bus_a.adc_data    = 12'(50 + (j - 1) / 4);
                if (j % 4 == 0) expect_a(3'd0, 12'(50 + (j - 1) / 4));
            end else begin
                bus_a.adc_valid = 1'b0;
            end
            @(negedge clock);
            exp_hi = ((j - 1) >= 16) ? 6'h3f : 6'h00;
            exp_r0 = ((j - 1) >= 56);
            total++;
            if (bus_a.vrail_stale[6:1] !== exp_hi) begin
                bad++;
                $display("FAIL stale_unfed: cycle %0d got %b required %b", j - 1, bus_a.vrail_stale[6:1], exp_hi);
            end
            total++;
            if (bus_a.vrail_stale[0] !== exp_r0) begin
                bad++;
                $display("FAIL stale_rail0: cycle %0d got %b required %b", j - 1, bus_a.vrail_stale[0], exp_r0);
            end
            @(posedge clock);
            #1;
        end
        total++; if (q_a.size() != 0) begin bad++; $display("FAIL stale_pending: got %0d outstanding required 0", q_a.size()); end
    endtask

    task automatic test_basic;
        do_reset();
        @(negedge clock);
        total++; if (bus_a.vrail_fresh !== 7'd0) begin bad++; $display("FAIL basic_fresh_after_reset: got %b required 0", bus_a.vrail_fresh); end
        drive_a(1'b1, 5'd1, 12'd100, 1'b0);
        drive_a(1'b1, 5'd1, 12'd104, 1'b0);
        drive_a(1'b1, 5'd1, 12'd108, 1'b0);
        drive_a(1'b1, 5'd1, 12'd112, 1'b0);
        expect_a(3'd0, 12'd106);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        @(negedge clock);
        total++; if (q_a.size() != 0) begin bad++; $display("FAIL basic_pending: got %0d outstanding required 0", q_a.size()); end
        total++; if (bus_a.vrail_fresh !== 7'b0000001) begin bad++; $display("FAIL basic_fresh: got %b required 0000001", bus_a.vrail_fresh); end
        total++; if (bus_a.vrail_level[11:0] !== 12'd106) begin bad++; $display("FAIL basic_level: got %0d required 106", bus_a.vrail_level[11:0]); end
    endtask

    task automatic test_fullscale_unmapped;
        for (int i = 0; i < 4; i++) drive_a(1'b1, 5'd8, 12'd4095, 1'b0);
        expect_a(3'd6, 12'd4095);
        for (int i = 0; i < 4; i++) drive_a(1'b1, 5'd0, 12'd7, 1'b0);
        for (int i = 0; i < 4; i++) drive_a(1'b1, 5'd7, 12'd9, 1'b0);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        @(negedge clock);
        total++; if (q_a.size() != 0) begin bad++; $display("FAIL full_pending: got %0d outstanding required 0", q_a.size()); end
        total++; if (bus_a.vrail_level[83:72] !== 12'd4095) begin bad++; $display("FAIL full_level6: got %0d required 4095", bus_a.vrail_level[83:72]); end
        total++; if (bus_a.vrail_level[71:12] !== 60'd0) begin bad++; $display("FAIL unmapped_levels: got %h required 0", bus_a.vrail_level[71:12]); end
        total++; if (bus_a.vrail_level[11:0] !== 12'd106) begin bad++; $display("FAIL unmapped_level0: got %0d required 106", bus_a.vrail_level[11:0]); end
        total++; if (bus_a.vrail_fresh !== 7'b1000001) begin bad++; $display("FAIL full_fresh: got %b required 1000001", bus_a.vrail_fresh); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) drive_a(1'b1, 5'd2, 12'd200, 1'b0);
        drive_a(1'b0, 5'd0, 12'd0, 1'b1);
        drive_a(1'b1, 5'd2, 12'd10, 1'b0);
        drive_a(1'b1, 5'd2, 12'd20, 1'b0);
        drive_a(1'b1, 5'd2, 12'd30, 1'b0);
        drive_a(1'b1, 5'd2, 12'd40, 1'b0);
        expect_a(3'd1, 12'd25);
        drive_a(1'b1, 5'd2, 12'd1, 1'b0);
        drive_a(1'b1, 5'd2, 12'd2, 1'b0);
        drive_a(1'b1, 5'd2, 12'd3, 1'b0);
        drive_a(1'b1, 5'd2, 12'd1000, 1'b1);
        for (int i = 4; i <= 7; i++) drive_a(1'b1, 5'd2, 12'(i), 1'b0);
        expect_a(3'd1, 12'd5);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        @(negedge clock);
        total++; if (q_a.size() != 0) begin bad++; $display("FAIL flush_pending: got %0d outstanding required 0", q_a.size()); end
        total++; if (bus_a.vrail_level[23:12] !== 12'd5) begin bad++; $display("FAIL flush_level1: got %0d required 5", bus_a.vrail_level[23:12]); end
        total++; if (bus_a.vrail_fresh !== 7'b1000011) begin bad++; $display("FAIL flush_fresh: got %b required 1000011", bus_a.vrail_fresh); end
    endtask

    task automatic test_chan_err;
        @(negedge clock);
        total++; if (bus_a.chan_err !== 1'b0) begin bad++; $display("FAIL chan_err_initial: got %b required 0", bus_a.chan_err); end
        drive_a(1'b1, 5'd12, 12'd55, 1'b0);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        @(negedge clock);
        total++; if (bus_a.chan_err !== 1'b1) begin bad++; $display("FAIL chan_err_set: got %b required 1", bus_a.chan_err); end
        for (int i = 0; i < 4; i++) drive_a(1'b1, 5'd3, 12'(1000 + i), 1'b0);
        expect_a(3'd2, 12'd1001);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        @(negedge clock);
        total++; if (bus_a.chan_err !== 1'b1) begin bad++; $display("FAIL chan_err_sticky: got %b required 1", bus_a.chan_err); end
        total++; if (q_a.size() != 0) begin bad++; $display("FAIL chan_err_pending: got %0d outstanding required 0", q_a.size()); end
        do_reset();
        @(negedge clock);
        total++; if (bus_a.chan_err !== 1'b0) begin bad++; $display("FAIL chan_err_cleared: got %b required 0", bus_a.chan_err); end
    endtask

    task automatic test_reset_mid;
        drive_a(1'b1, 5'd4, 12'd500, 1'b0);
        drive_a(1'b1, 5'd4, 12'd500, 1'b0);
        for (int i = 0; i < 4; i++) drive_a(1'b1, 5'd3, 12'd900, 1'b0);
        expect_a(3'd2, 12'd900);
        do_reset();
        @(negedge clock);
        total++; if (bus_a.vrail_level !== '0) begin bad++; $display("FAIL mid_reset_level: got %h required 0", bus_a.vrail_level); end
        total++; if (bus_a.avg_data !== 12'd0 || bus_a.avg_rail !== 3'd0) begin
            bad++; $display("FAIL mid_reset_avg: got rail=%0d data=%0d required 0/0", bus_a.avg_rail, bus_a.avg_data); end
        total++; if (bus_a.vrail_fresh !== 7'd0) begin bad++; $display("FAIL mid_reset_fresh: got %b required 0", bus_a.vrail_fresh); end
        for (int i = 0; i < 4; i++) drive_a(1'b1, 5'd4, 12'd8, 1'b0);
        expect_a(3'd3, 12'd8);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        drive_a(1'b0, 5'd0, 12'd0, 1'b0);
        @(negedge clock);
        total++; if (q_a.size() != 0) begin bad++; $display("FAIL mid_reset_pending: got %0d outstanding required 0", q_a.size()); end
    endtask

    task automatic test_back_to_back_passthrough;
        logic [4:0]  ch;
        logic [11:0] d;
        exp_t        ep;
        for (int i = 0; i < 20; i++) begin
            ch = (i % 2 == 0) ? 5'd3 : 5'd5;
            d  = 12'($urandom_range(0, 4095));
            drive_p(1'b1, ch, d);
            ep.rail = (ch == 5'd3) ? 3'd2 : 3'd4;
            ep.data = d;
            ep.due  = cyc + 1;
            q_p.push_back(ep);
        end
        drive_p(1'b0, 5'd0, 12'd0);
        drive_p(1'b0, 5'd0, 12'd0);
        @(negedge clock);
        total++; if (q_p.size() != 0) begin bad++; $display("FAIL pass_pending: got %0d outstanding required 0", q_p.size()); end
        total++; if (bus_p.vrail_fresh !== 7'b0010100) begin bad++; $display("FAIL pass_fresh: got %b required 0010100", bus_p.vrail_fresh); end
    endtask

    initial begin
        bus_a.adc_valid = 1'b0; bus_a.adc_channel = 5'd0; bus_a.adc_data = 12'd0; bus_a.flush = 1'b0;
        bus_p.adc_valid = 1'b0; bus_p.adc_channel = 5'd0; bus_p.adc_data = 12'd0; bus_p.flush = 1'b0;
        test_reset();
        test_stale();
        test_basic();
        test_fullscale_unmapped();
        test_flush();
        test_chan_err();
        test_reset_mid();
        test_back_to_back_passthrough();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
